xpb_csa_accum: RTL



---
 rtl/xpb_pkg.sv | 13 +
 rtl/csa_3to2.sv | 13 +
 rtl/xpb_csa_accum.sv | 97 +++++++++
 3 files changed

// File: rtl/xpb_pkg.sv
// xpb_pkg: shared widths, derived-size helpers and accumulator state encoding for the XPB path
package xpb_pkg;
  localparam int DATA_W_DEF = 1024;
  localparam int GUARD_W_DEF = 10;
  localparam int CHUNK_W_DEF = 64;
  typedef enum logic [1:0] {ACC, RESOLVE, DONE} xpb_acc_state_t;
  function automatic int acc_w(input int data_w, input int guard_w);
    return data_w + guard_w;
  endfunction
  function automatic int nchunk(input int acc_width, input int chunk_w);
    return (acc_width + chunk_w - 1) / chunk_w;
  endfunction
endpackage

// File: rtl/csa_3to2.sv
// csa_3to2: width-W 3:2 compressor, carry returned unshifted
module csa_3to2 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] x,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);
  assign sum = a ^ b ^ x;
  assign carry = (a & b) | (a & x) | (b & x);
endmodule

// File: rtl/xpb_csa_accum.sv
// xpb_csa_accum: carry-save burst accumulator with chunked resolve; XPB_ACC_TERM_CHECK_EN adds sticky err_ovf
module xpb_csa_accum
  import xpb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int GUARD_W = GUARD_W_DEF,
  parameter int CHUNK_W = CHUNK_W_DEF,
  parameter int ACC_W = acc_w(DATA_W, GUARD_W),
  parameter int NCHUNK = nchunk(ACC_W, CHUNK_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [GUARD_W:0]  out_terms
`ifdef XPB_ACC_TERM_CHECK_EN
  , output logic            err_ovf
`endif
);
  localparam int IDX_W = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  localparam logic [GUARD_W:0] CNT_LIM = (GUARD_W + 1)'(1) << GUARD_W;
  xpb_acc_state_t state, state_nxt;
  logic [ACC_W-1:0] s, c, r, csa_s, csa_c;
  logic [IDX_W-1:0] idx;
  logic cin;
  logic [GUARD_W:0] cnt;
  logic acc_fire, last_chunk;
  logic [31:0] sh;
  logic [CHUNK_W-1:0] s_sl, c_sl;
  logic [CHUNK_W:0] csum;
  assign acc_fire = in_valid && in_ready;
  assign last_chunk = idx == IDX_W'(NCHUNK - 1);
  assign sh = 32'(idx) * 32'(CHUNK_W);
  assign s_sl = CHUNK_W'(s >> sh);
  assign c_sl = CHUNK_W'(c >> sh);
  assign csum = {1'b0, s_sl} + {1'b0, c_sl} + (CHUNK_W + 1)'(cin);
  assign out_data = r;
  assign out_terms = cnt;
  csa_3to2 #(.W(ACC_W)) u_csa (
    .a(s),
    .b(c),
    .x(ACC_W'(in_data)),
    .sum(csa_s),
    .carry(csa_c)
  );
  // state register
  always_ff @(posedge clk)
    state <= rst ? ACC : state_nxt;
  // next state: accept until last term, one resolve cycle per chunk, hold result until taken
  always_comb
    state_nxt = state == ACC ? (acc_fire && in_last ? RESOLVE : ACC) :
                state == RESOLVE ? (last_chunk ? DONE : RESOLVE) :
                (out_ready ? ACC : DONE);
  // handshake outputs decoded from registered state only
  always_comb begin
    in_ready = state == ACC;
    out_valid = state == DONE;
  end
  // datapath: CSA fold on accept, chunk add during resolve, clear on result consumption
  always_ff @(posedge clk) begin
    if (rst) begin
      s <= '0;
      c <= '0;
      r <= '0;
      idx <= '0;
      cin <= 1'b0;
      cnt <= '0;
    end else if (acc_fire) begin
      s <= csa_s;
      c <= csa_c << 1;
      cnt <= cnt == '1 ? cnt : cnt + 1'b1;
      if (in_last) begin
        idx <= '0;
        cin <= 1'b0;
      end
    end else if (state == RESOLVE) begin
      r <= r | (ACC_W'(csum[CHUNK_W-1:0]) << sh);
      cin <= csum[CHUNK_W];
      idx <= idx + 1'b1;
    end else if (state == DONE && out_ready) begin
      s <= '0;
      c <= '0;
      r <= '0;
      cnt <= '0;
    end
  end
`ifdef XPB_ACC_TERM_CHECK_EN
  // sticky flag for a term accepted past the guard-bit headroom
  always_ff @(posedge clk)
    err_ovf <= rst ? 1'b0 : err_ovf | (acc_fire && cnt == CNT_LIM);
`endif
endmodule
